// File: rtl/fork_join_tracker.sv
// Hardware model of fork/join: one start launches NUM_CH countdown channels, parent released per mode.
// Optional FORK_DISABLE_EN adds disable_fork/aborted to kill a run in progress.
module fork_join_tracker #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef FORK_DISABLE_EN
  input  logic                      disable_fork,
  output logic                      aborted,
`endif
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH*CNT_W-1:0]   delay,
  output logic [NUM_CH-1:0]         ch_done,
  output logic [NUM_CH-1:0]         ch_busy,
  output logic                      join_done,
  output logic [$clog2(NUM_CH)-1:0] first_id,
  output logic                      busy
);

  localparam int ID_W = $clog2(NUM_CH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] done_q, done_d;
  logic              join_q, join_d;
  logic              fired_q, fired_d;
  logic              first_seen_q, first_seen_d;
  logic [ID_W-1:0]   first_id_q, first_id_d;
  logic [ID_W-1:0]   low_id;
  logic              all_zero;
  logic              join_cond;
`ifdef FORK_DISABLE_EN
  logic              aborted_q, aborted_d;
`endif

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    done_d       = '0;
    join_d       = 1'b0;
    fired_d      = fired_q;
    first_seen_d = first_seen_q;
    first_id_d   = first_id_q;
    low_id       = '0;
    all_zero     = 1'b1;
    join_cond    = 1'b0;
`ifdef FORK_DISABLE_EN
    aborted_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_RUN;
          mode_d       = mode;
          fired_d      = 1'b0;
          first_seen_d = 1'b0;
          first_id_d   = '0;
          // A zero delay still takes one cycle, so it is loaded as 1.
          for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_en[i])
              cnt_d[i] = '0;
            else if (delay[i*CNT_W +: CNT_W] == '0)
              cnt_d[i] = CNT_W'(1);
            else
              cnt_d[i] = delay[i*CNT_W +: CNT_W];
          end
        end
      end
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
            if (cnt_q[i] == CNT_W'(1))
              done_d[i] = 1'b1;
          end
          if (cnt_d[i] != '0)
            all_zero = 1'b0;
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (done_d[i])
            low_id = ID_W'(i);
        end
        // An empty channel set releases the parent one cycle after launch in every mode.
        case (mode_q)
          2'b01:   join_cond = (|done_d) || all_zero;
          2'b10:   join_cond = 1'b1;
          default: join_cond = all_zero;
        endcase
        if (!fired_q && join_cond) begin
          join_d  = 1'b1;
          fired_d = 1'b1;
        end
        if (!first_seen_q && (|done_d)) begin
          first_seen_d = 1'b1;
          first_id_d   = low_id;
        end
        if (all_zero)
          state_d = ST_IDLE;
`ifdef FORK_DISABLE_EN
        if (disable_fork) begin
          for (int i = 0; i < NUM_CH; i++)
            cnt_d[i] = '0;
          done_d       = '0;
          join_d       = 1'b0;
          first_seen_d = first_seen_q;
          first_id_d   = first_id_q;
          state_d      = ST_IDLE;
          aborted_d    = 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= '0;
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= '0;
      done_q       <= '0;
      join_q       <= 1'b0;
      fired_q      <= 1'b0;
      first_seen_q <= 1'b0;
      first_id_q   <= '0;
`ifdef FORK_DISABLE_EN
      aborted_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      join_q       <= join_d;
      fired_q      <= fired_d;
      first_seen_q <= first_seen_d;
      first_id_q   <= first_id_d;
`ifdef FORK_DISABLE_EN
      aborted_q    <= aborted_d;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      ch_busy[i] = (cnt_q[i] != '0);
  end

  assign ch_done   = done_q;
  assign join_done = join_q;
  assign first_id  = first_id_q;
  assign busy      = (state_q == ST_RUN);
`ifdef FORK_DISABLE_EN
  assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_fork_join_tracker.sv
// Self-checking bench for fork_join_tracker: vector table, directed corner sequences,
// and randomized runs against a per-cycle timing model.
module tb_fork_join_tracker;

   localparam int NCH = 4;
   localparam int CW  = 8;

   logic          clk;
   logic          rstN;
   logic          start;
   logic [1:0]    mode;
   logic [NCH-1:0] chEn;
   logic [NCH*CW-1:0] delay;
   logic [NCH-1:0] chDone;
   logic [NCH-1:0] chBusy;
   logic          joinDone;
   logic [1:0]    firstId;
   logic          busy;
`ifdef FORK_DISABLE_EN
   logic          disableFork;
   logic          aborted;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]  vMode;
      logic [3:0]  vEn;
      logic [31:0] vDly;
      int          expJoin;
      int          expFirst;
      int          expBusy;
      int          expDones;
   } vec_t;

   vec_t vecs[9];

   fork_join_tracker #(.NUM_CH(NCH), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rstN),
`ifdef FORK_DISABLE_EN
      .disable_fork(disableFork),
      .aborted    (aborted),
`endif
      .start      (start),
      .mode       (mode),
      .ch_en      (chEn),
      .delay      (delay),
      .ch_done    (chDone),
      .ch_busy    (chBusy),
      .join_done  (joinDone),
      .first_id   (firstId),
      .busy       (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] packDelay(input int d0, input int d1, input int d2, input int d3);
      packDelay = {d3[7:0], d2[7:0], d1[7:0], d0[7:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic [1:0] m, input logic [3:0] e, input logic [31:0] d);
      start = s;
      mode  = m;
      chEn  = e;
      delay = d;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Launch a run; returns positioned in the cycle after the launching edge (k=0)
   task automatic launch(input logic [1:0] m, input logic [3:0] e, input logic [31:0] d);
      applyStimulus(1'b1, m, e, d);
      tick();
      applyStimulus(1'b0, 2'b00, 4'b0000, 32'h0);
   endtask

   // Observe a run for a number of cycles and summarise what happened
   task automatic observe(input int window, output int joinAt, output int joinCnt,
                          output int busyCnt, output int doneCnt, output int done1At);
      joinAt  = -1;
      joinCnt = 0;
      busyCnt = 0;
      doneCnt = 0;
      done1At = -1;
      for (int k = 0; k < window; k++) begin
         if (joinDone) begin
            joinCnt++;
            if (joinAt < 0) joinAt = k;
         end
         if (busy) busyCnt++;
         for (int i = 0; i < NCH; i++) if (chDone[i]) doneCnt++;
         if (chDone[1] && done1At < 0) done1At = k;
         tick();
      end
   endtask

   initial begin
      int joinAt, joinCnt, busyCnt, doneCnt, done1At;
      int effD[NCH];
      int dMax, dMin, runLen, expJoinK, expFirst, startAt;
      logic [1:0]  rMode;
      logic [3:0]  rEn;
      logic [31:0] rDly;
      logic [3:0]  expDoneV, expBusyV;

      rstN = 1'b0;
      applyStimulus(1'b0, 2'b00, 4'b0000, 32'h0);
`ifdef FORK_DISABLE_EN
      disableFork = 1'b0;
`endif

      vecs[0] = '{2'b01, 4'b0011, packDelay(5, 10, 0, 0),  5, 0, 10, 2};
      vecs[1] = '{2'b00, 4'b1111, packDelay(3, 7, 2, 7),   7, 2, 7, 4};
      vecs[2] = '{2'b10, 4'b1111, packDelay(4, 4, 4, 4),   1, 0, 4, 4};
      vecs[3] = '{2'b11, 4'b1111, packDelay(1, 2, 3, 4),   4, 0, 4, 4};
      vecs[4] = '{2'b00, 4'b0000, packDelay(9, 9, 9, 9),   1, 0, 1, 0};
      vecs[5] = '{2'b01, 4'b0000, packDelay(3, 3, 3, 3),   1, 0, 1, 0};
      vecs[6] = '{2'b01, 4'b1111, packDelay(7, 0, 3, 9),   1, 1, 9, 4};
      vecs[7] = '{2'b01, 4'b1110, packDelay(6, 3, 3, 8),   3, 1, 8, 3};
      vecs[8] = '{2'b00, 4'b0100, packDelay(0, 0, 255, 0), 255, 2, 255, 1};

      #12;
      checkOutput("reset_outputs", {22'h0, chDone, chBusy, joinDone, firstId, busy}, 32'h0);
      tick();
      rstN = 1'b1;
      tick();

      $display("[TB] vector table");
      for (int v = 0; v < 9; v++) begin
         launch(vecs[v].vMode, vecs[v].vEn, vecs[v].vDly);
         observe(vecs[v].expBusy + 4, joinAt, joinCnt, busyCnt, doneCnt, done1At);
         checkOutput($sformatf("vec%0d_join_at", v), joinAt, vecs[v].expJoin);
         checkOutput($sformatf("vec%0d_join_cnt", v), joinCnt, 1);
         checkOutput($sformatf("vec%0d_first_id", v), {30'h0, firstId}, vecs[v].expFirst);
         checkOutput($sformatf("vec%0d_busy_cycles", v), busyCnt, vecs[v].expBusy);
         checkOutput($sformatf("vec%0d_done_count", v), doneCnt, vecs[v].expDones);
      end

      $display("[TB] restart ignored while running");
      launch(2'b00, 4'b1111, packDelay(5, 0, 3, 6));
      tick();
      applyStimulus(1'b1, 2'b10, 4'b0001, packDelay(1, 1, 1, 1));
      begin
         // k=1 here: ch1 (zero delay) should be pulsing now
         checkOutput("restart_ch1_done_k1", {28'h0, chDone}, 32'h2);
         tick();
         applyStimulus(1'b0, 2'b00, 4'b0000, 32'h0);
      end
      observe(10, joinAt, joinCnt, busyCnt, doneCnt, done1At);
      checkOutput("restart_join_at", joinAt, 6 - 2);
      checkOutput("restart_join_cnt", joinCnt, 1);
      checkOutput("restart_first_id", {30'h0, firstId}, 1);
      checkOutput("restart_busy_cycles", busyCnt, 6 - 2);

      $display("[TB] reset in the middle of a run");
      launch(2'b00, 4'b0001, packDelay(10, 0, 0, 0));
      tick();
      tick();
      tick();
      rstN = 1'b0;
      #1;
      checkOutput("midreset_outputs", {22'h0, chDone, chBusy, joinDone, firstId, busy}, 32'h0);
      tick();
      tick();
      rstN = 1'b1;
      observe(15, joinAt, joinCnt, busyCnt, doneCnt, done1At);
      checkOutput("midreset_no_join", joinCnt, 0);
      checkOutput("midreset_no_done", doneCnt, 0);
      checkOutput("midreset_no_busy", busyCnt, 0);

`ifdef FORK_DISABLE_EN
      $display("[TB] disable_fork abort");
      launch(2'b00, 4'b0011, packDelay(6, 9, 0, 0));
      for (int k = 0; k < 4; k++) tick();
      disableFork = 1'b1;
      tick();
      disableFork = 1'b0;
      checkOutput("abort_pulse", {31'h0, aborted}, 1);
      checkOutput("abort_busy", {31'h0, busy}, 0);
      checkOutput("abort_ch_busy", {28'h0, chBusy}, 0);
      tick();
      checkOutput("abort_pulse_one_cycle", {31'h0, aborted}, 0);
      observe(12, joinAt, joinCnt, busyCnt, doneCnt, done1At);
      checkOutput("abort_no_join", joinCnt, 0);
      checkOutput("abort_no_done", doneCnt, 0);
`endif

      $display("[TB] randomized runs");
      for (int r = 0; r < 60; r++) begin
         rMode = 2'($urandom_range(0, 3));
         rEn   = 4'($urandom_range(0, 15));
         rDly  = 32'h0;
         for (int i = 0; i < NCH; i++) rDly[i*8 +: 8] = 8'($urandom_range(0, 20));
         dMax = 0;
         dMin = 1000;
         for (int i = 0; i < NCH; i++) begin
            effD[i] = rEn[i] ? ((rDly[i*8 +: 8] == 0) ? 1 : int'(rDly[i*8 +: 8])) : 0;
            if (rEn[i] && effD[i] > dMax) dMax = effD[i];
            if (rEn[i] && effD[i] < dMin) dMin = effD[i];
         end
         runLen = (rEn == 0) ? 1 : dMax;
         expFirst = 0;
         for (int i = NCH - 1; i >= 0; i--) if (rEn[i] && effD[i] == dMin) expFirst = i;
         case (rMode)
            2'b01:   expJoinK = (rEn == 0) ? 1 : dMin;
            2'b10:   expJoinK = 1;
            default: expJoinK = runLen;
         endcase
         startAt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, runLen - 1)) : -1;
         launch(rMode, rEn, rDly);
         for (int k = 0; k <= runLen + 1; k++) begin
            expDoneV = '0;
            expBusyV = '0;
            for (int i = 0; i < NCH; i++) begin
               expDoneV[i] = rEn[i] && (k == effD[i]);
               expBusyV[i] = rEn[i] && (k < effD[i]);
            end
            checkOutput($sformatf("rnd%0d_k%0d_ch_done", r, k), {28'h0, chDone}, {28'h0, expDoneV});
            checkOutput($sformatf("rnd%0d_k%0d_ch_busy", r, k), {28'h0, chBusy}, {28'h0, expBusyV});
            checkOutput($sformatf("rnd%0d_k%0d_join", r, k), {31'h0, joinDone}, (k == expJoinK) ? 1 : 0);
            checkOutput($sformatf("rnd%0d_k%0d_busy", r, k), {31'h0, busy}, (k < runLen) ? 1 : 0);
            checkOutput($sformatf("rnd%0d_k%0d_first_id", r, k), {30'h0, firstId},
                        (rEn != 0 && k >= dMin) ? expFirst : 0);
            if (k == startAt)
               applyStimulus(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), $urandom);
            tick();
            applyStimulus(1'b0, 2'b00, 4'b0000, 32'h0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case something stalls the main sequence
   initial begin
      #500000;
      $display("[TB] FAIL timeout actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
